// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a burst-fill FSM in front of the IF stage.
// Defining ICACHE_PERF_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module icache_fill_ctrl #(
  parameter int SETS  = 64,
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req_i,
  input  logic [15:0] fetch_addr_i,
  input  logic        inv_all_i,
  output logic [15:0] instr_o,
  output logic        instr_valid_o,
  output logic        stall_o,
  output logic        mem_en_o,
  output logic [15:0] mem_addr_o,
  input  logic [15:0] mem_data_i,
  input  logic        mem_data_valid_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
`endif
);
  localparam int IDXW = $clog2(SETS);
  localparam int OFFW = $clog2(WORDS);
  localparam int TAGW = 12 - IDXW;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [11:0]     blk_q, blk_d;
  logic [OFFW:0]   iss_q, iss_d;
  logic [OFFW-1:0] rcv_q, rcv_d;
  logic            drop_q, drop_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [15:0]     data_q [SETS*WORDS];

  logic [IDXW-1:0] lk_idx, fill_idx;
  logic [TAGW-1:0] lk_tag;
  logic [OFFW-1:0] lk_off;
  logic            is_idle, hit, miss, fill_wr, fill_last;
  logic            unused_addr_b0;

  assign lk_idx         = fetch_addr_i[3+IDXW:4];
  assign lk_tag         = fetch_addr_i[15:4+IDXW];
  assign lk_off         = fetch_addr_i[3:1];
  assign unused_addr_b0 = fetch_addr_i[0];
  assign fill_idx       = blk_q[IDXW-1:0];

  assign is_idle   = (state_q == S_IDLE);
  assign hit       = is_idle & fetch_req_i & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign miss      = is_idle & fetch_req_i & ~hit;
  assign fill_wr   = ~is_idle & mem_data_valid_i;
  assign fill_last = fill_wr & (rcv_q == OFFW'(WORDS-1));

  assign instr_valid_o = hit;
  assign instr_o       = hit ? data_q[{lk_idx, lk_off}] : 16'h0000;
  // rst_n gating keeps stall low while reset is held even if the IF stage keeps requesting
  assign stall_o       = rst_n & (miss | ~is_idle);
  assign mem_en_o      = ~is_idle & ~iss_q[OFFW];
  assign mem_addr_o    = mem_en_o ? {blk_q, iss_q[OFFW-1:0], 1'b0} : 16'h0000;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    if (inv_all_i) valid_d = '0;
    if (is_idle) begin
      if (miss) begin
        state_d = S_FILL;
        blk_d   = fetch_addr_i[15:4];
        iss_d   = '0;
        rcv_d   = '0;
        drop_d  = 1'b0;
      end
    end else begin
      if (mem_en_o)  iss_d  = iss_q + 1'b1;
      if (inv_all_i) drop_d = 1'b1;
      if (fill_wr)   rcv_d  = rcv_q + 1'b1;
      // An invalidate that lands during the fill (even on its last beat) leaves the line invalid
      if (fill_last) begin
        valid_d[fill_idx] = ~(drop_q | inv_all_i);
        state_d           = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      drop_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr)   data_q[{fill_idx, rcv_q}] <= mem_data_i;
    if (fill_last) tag_q[fill_idx]            <= blk_q[11:IDXW];
  end

`ifdef ICACHE_PERF_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit  && (hit_cnt_q  != 16'hFFFF)) hit_cnt_d  = hit_cnt_q  + 16'd1;
    if (miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
